// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences fetch, decode,
// memory, ALU, branch and jump steps and drives the datapath strobes and selects.
module multicycle_control_fsm #(
    parameter int OP_W    = 6,
    parameter bit WAIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            iord,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            branch,
    output logic            memwrite,
    output logic            regwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsrc,
    output logic            illegal_op,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t          state_r;
    state_t          state_nxt_s;
    state_t          decode_nxt_s;
    logic [OP_W-1:0] op_r;
    logic            rdy_s;

    // Successor of DECODE; FETCH doubles as the "unsupported opcode" result.
    function automatic state_t decode_target(input logic [OP_W-1:0] op);
        state_t nxt;
        if ((op >> 6) != {OP_W{1'b0}}) begin
            nxt = FETCH;
        end else begin
            case (op[5:0])
                OP_RTYPE: nxt = EXECUTE;
                OP_LW:    nxt = MEMADR;
                OP_SW:    nxt = MEMADR;
                OP_BEQ:   nxt = BRANCH;
                OP_ADDI:  nxt = ADDIEX;
                OP_J:     nxt = JUMP;
                default:  nxt = FETCH;
            endcase
        end
        return nxt;
    endfunction

    assign rdy_s        = WAIT_EN ? mem_ready : 1'b1;
    assign decode_nxt_s = decode_target(opcode);
    assign state        = state_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Opcode latched in DECODE so MEMADR does not depend on the live bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= {OP_W{1'b0}};
        end else if (state_r == DECODE) begin
            op_r <= opcode;
        end else begin
            op_r <= op_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = FETCH;
        case (state_r)
            FETCH:   state_nxt_s = rdy_s ? DECODE : FETCH;
            DECODE:  state_nxt_s = decode_nxt_s;
            MEMADR: begin
                if (op_r == OP_W'(OP_LW)) begin
                    state_nxt_s = MEMRD;
                end else if (op_r == OP_W'(OP_SW)) begin
                    state_nxt_s = MEMWR;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            MEMRD:   state_nxt_s = rdy_s ? MEMWB : MEMRD;
            MEMWR:   state_nxt_s = rdy_s ? FETCH : MEMWR;
            EXECUTE: state_nxt_s = ALUWB;
            ADDIEX:  state_nxt_s = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_nxt_s = FETCH;
            default: state_nxt_s = FETCH;
        endcase
    end

    // Moore output decode; FETCH strobes are gated by reset so nothing fires while held.
    always_comb begin
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        illegal_op = 1'b0;
        case (state_r)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = rdy_s & rst_n;
                pcwrite = rdy_s & rst_n;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = (decode_nxt_s == FETCH);
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: alusrcb = 2'b01;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares against two DUT configurations.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst0_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [7:0] op8 = 8'd0;
    logic       mem_ready = 1'b0;

    logic       iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       illegal_op;
    logic [3:0] state;

    logic       d0_iord, d0_irwrite, d0_pcwrite, d0_branch, d0_memwrite, d0_regwrite;
    logic       d0_regdst, d0_memtoreg, d0_alusrca, d0_illegal_op;
    logic [1:0] d0_alusrcb, d0_aluop, d0_pcsrc;
    logic [3:0] d0_state;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] outs;
        logic        ill;
        logic [3:0]  st0;
        logic        ill0;
        logic        irw0;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OP_W(6), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .illegal_op(illegal_op), .state(state)
    );

    multicycle_control_fsm #(.OP_W(8), .WAIT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .opcode(op8), .mem_ready(1'b0),
        .iord(d0_iord), .irwrite(d0_irwrite), .pcwrite(d0_pcwrite), .branch(d0_branch),
        .memwrite(d0_memwrite), .regwrite(d0_regwrite), .regdst(d0_regdst),
        .memtoreg(d0_memtoreg), .alusrca(d0_alusrca), .alusrcb(d0_alusrcb),
        .aluop(d0_aluop), .pcsrc(d0_pcsrc), .illegal_op(d0_illegal_op), .state(d0_state)
    );

    // Output table per state, packed {iord,irw,pcw,br,mw,rw,rd,mtr,asa,asb,aop,psrc}.
    function automatic logic [14:0] spec_outs(input logic [3:0] st, input logic rdy);
        logic       io, irw, pcw, br, mw, rw, rd, mtr, asa;
        logic [1:0] asb, aop, psrc;
        {io, irw, pcw, br, mw, rw, rd, mtr, asa} = 9'd0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0: begin asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1: asb = 2'b11;
            4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
            4'd3: io = 1'b1;
            4'd4: begin mtr = 1'b1; rw = 1'b1; end
            4'd5: begin io = 1'b1; mw = 1'b1; end
            4'd6: begin asa = 1'b1; aop = 2'b10; end
            4'd7: begin rd = 1'b1; rw = 1'b1; end
            4'd8: begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; br = 1'b1; end
            4'd10: rw = 1'b1;
            4'd11: begin psrc = 2'b10; pcw = 1'b1; end
            default: asb = 2'b00;
        endcase
        return {io, irw, pcw, br, mw, rw, rd, mtr, asa, asb, aop, psrc};
    endfunction

    task automatic drive(input logic rn, input logic rdy, input logic [5:0] op,
                         input logic r0n, input logic [7:0] o8,
                         input logic [3:0] est, input logic eill,
                         input logic [3:0] est0, input logic eill0, input logic eirw0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; mem_ready = rdy; opcode = op; rst0_n = r0n; op8 = o8;
        e.st = est; e.outs = spec_outs(est, rn & rdy); e.ill = eill;
        e.st0 = est0; e.ill0 = eill0; e.irw0 = eirw0;
        q.push_back(e);
    endtask

    task automatic m(input logic rdy, input logic [5:0] op, input logic [3:0] est, input logic eill);
        drive(1'b1, rdy, op, 1'b0, 8'h00, est, eill, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic w(input logic [7:0] o8, input logic [3:0] est0, input logic eill0);
        drive(1'b0, 1'b1, 6'h00, 1'b1, o8, 4'd0, 1'b0, est0, eill0, est0 == 4'd0);
    endtask

    // Monitor: every cycle the DUTs present a full output vector to compare.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [14:0] got;
            e = q.pop_front();
            got = {iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, aluop, pcsrc};
            tests++;
            if (state !== e.st) begin
                fails++; $display("FAIL state t=%0t got %0d exp %0d", $time, state, e.st);
            end
            tests++;
            if (got !== e.outs) begin
                fails++; $display("FAIL outs t=%0t got %b exp %b", $time, got, e.outs);
            end
            tests++;
            if (illegal_op !== e.ill) begin
                fails++; $display("FAIL illegal_op t=%0t got %b exp %b", $time, illegal_op, e.ill);
            end
            tests++;
            if (d0_state !== e.st0) begin
                fails++; $display("FAIL nowait_state t=%0t got %0d exp %0d", $time, d0_state, e.st0);
            end
            tests++;
            if (d0_illegal_op !== e.ill0) begin
                fails++; $display("FAIL nowait_illegal t=%0t got %b exp %b", $time, d0_illegal_op, e.ill0);
            end
            tests++;
            if (d0_irwrite !== e.irw0) begin
                fails++; $display("FAIL nowait_irwrite t=%0t got %b exp %b", $time, d0_irwrite, e.irw0);
            end
        end
    end

    initial begin
        // reset held with mem_ready high: strobes must stay low
        drive(1'b0, 1'b1, 6'h00, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 6'h00, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        // lw from reset: 0,1,2,3,4,0 (live opcode changed after DECODE)
        m(1'b1, 6'h23, 4'd0, 1'b0);
        m(1'b1, 6'h23, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd2, 1'b0);
        m(1'b1, 6'h00, 4'd3, 1'b0);
        m(1'b1, 6'h00, 4'd4, 1'b0);
        // FETCH stall then sw with three wait cycles in MEMWR
        m(1'b0, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h2B, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd2, 1'b0);
        m(1'b0, 6'h00, 4'd5, 1'b0);
        m(1'b0, 6'h00, 4'd5, 1'b0);
        m(1'b0, 6'h00, 4'd5, 1'b0);
        m(1'b1, 6'h00, 4'd5, 1'b0);
        // beq then j
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h04, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd8, 1'b0);
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h02, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd11, 1'b0);
        // illegal opcode 111111
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h3F, 4'd1, 1'b1);
        // addi
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h08, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd9, 1'b0);
        m(1'b1, 6'h00, 4'd10, 1'b0);
        // R-type
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h00, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd6, 1'b0);
        m(1'b1, 6'h00, 4'd7, 1'b0);
        // sw stalled in MEMWR, then asynchronous reset mid-cycle
        m(1'b1, 6'h00, 4'd0, 1'b0);
        m(1'b1, 6'h2B, 4'd1, 1'b0);
        m(1'b1, 6'h00, 4'd2, 1'b0);
        m(1'b0, 6'h00, 4'd5, 1'b0);
        m(1'b0, 6'h00, 4'd5, 1'b0);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        // no-wait 8-bit instance, mem_ready tied low: R-type, upper-bit illegal, lw
        w(8'h00, 4'd0, 1'b0);
        w(8'h00, 4'd1, 1'b0);
        w(8'h00, 4'd6, 1'b0);
        w(8'h00, 4'd7, 1'b0);
        w(8'h00, 4'd0, 1'b0);
        w(8'h40, 4'd1, 1'b1);
        w(8'h00, 4'd0, 1'b0);
        w(8'h23, 4'd1, 1'b0);
        w(8'h00, 4'd2, 1'b0);
        w(8'h00, 4'd3, 1'b0);
        w(8'h00, 4'd4, 1'b0);
        w(8'h00, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++; $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode field width.
REQ-002 SHALL have parameter WAIT_EN, default 1; 1 means honour mem_ready, 0 means treat mem_ready as constant 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port opcode, input, OP_W bits: instruction[31:26], sampled only in DECODE.
REQ-006 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-007 SHALL have outputs iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst, memtoreg and alusrca, each 1 bit: datapath strobes and selects.
REQ-008 SHALL have outputs alusrcb, aluop and pcsrc, each 2 bits: ALU operand-B select, ALU decoder op, and PC source.
REQ-009 SHALL have output illegal_op, 1 bit: unsupported opcode flag.
REQ-010 SHALL have output state, 4 bits: current state encoding, for debug.

Function
REQ-011 SHALL be a Moore FSM; all outputs are decoded from state only, except irwrite and pcwrite in FETCH and illegal_op, which may also depend on inputs.
REQ-012 SHALL use the following state encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Encodings 12-15 are illegal and SHALL go to FETCH on the next edge.
REQ-013 SHALL drive outputs per state as listed below; any output not listed is 0 in that state.
- FETCH: alusrcb=01; irwrite=pcwrite=mem_ready.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-014 SHALL hold FETCH while mem_ready=0 and go to DECODE on the edge where mem_ready=1.
REQ-015 SHALL transition from DECODE by opcode:
- 000000 -> EXECUTE
- 100011 and 101011 -> MEMADR
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other value -> FETCH
REQ-016 SHALL compare only the low 6 bits of opcode when OP_W>6 and SHALL require the upper bits to be zero; a nonzero upper bit is an illegal opcode.
REQ-017 SHALL transition from MEMADR to MEMRD for lw (100011) and to MEMWR for sw (101011), using the opcode value latched in DECODE, not the live input.
REQ-018 SHALL hold MEMRD and MEMWR while mem_ready=0.
REQ-019 SHALL keep memwrite asserted for every cycle spent in MEMWR.
REQ-020 SHALL, on mem_ready=1, go from MEMRD to MEMWB and from MEMWR to FETCH.
REQ-021 SHALL make these transitions unconditionally:
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
REQ-022 SHALL assert illegal_op for exactly one cycle, in DECODE, when the opcode is unsupported.
REQ-023 SHALL give these instruction latencies with mem_ready held at 1, counting FETCH to the next FETCH:
- lw: 5 cycles
- sw, R-type and addi: 4 cycles
- beq and j: 3 cycles
- illegal opcode: 2 cycles
REQ-024 SHALL let each additional mem_ready=0 cycle in FETCH, MEMRD or MEMWR add exactly one cycle of latency.
REQ-025 SHALL, when WAIT_EN=0, never stall and ignore mem_ready entirely.
REQ-026 SHALL register the opcode on the DECODE edge into an internal OP_W-bit register; that register resets to 0.

Reset
REQ-027 SHALL force state=FETCH on rst_n=0 immediately, without waiting for clk, including mid-instruction, e.g. during MEMWR.
REQ-028 SHALL, while in reset, drive every output as in FETCH with mem_ready treated as 0: alusrcb=01 and all other outputs 0, so memwrite=0 and regwrite=0.
REQ-029 SHALL leave FETCH on the first rising clk edge after rst_n deasserts if mem_ready=1.

Verification
REQ-030 SHALL cover lw (100011) with mem_ready=1 from reset: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-031 SHALL cover sw with mem_ready=0 for 3 cycles in MEMWR: memwrite=1 for 4 consecutive cycles, then state returns to 0.
REQ-032 SHALL cover beq, then j: sequence 0,1,8,0,1,11,0; pcsrc=01 with branch=1 in state 8; pcsrc=10 with pcwrite=1 in state 11.
REQ-033 SHALL cover opcode 111111: illegal_op=1 for one cycle in state 1, next state 0, and no regwrite, memwrite or pcwrite outside FETCH.
REQ-034 SHALL cover rst_n asserted low asynchronously mid-MEMWR: memwrite falls before the next clk edge and state=0.
REQ-035 SHALL cover WAIT_EN=0 with mem_ready tied to 0: an R-type instruction completes in 4 cycles with sequence 0,1,6,7,0.
